// File: rtl/case_4_mul_pipe.sv
// Pipelined signed/unsigned multiplier with valid/ready backpressure and overflow flag on the narrowed result.
// Build option: define CASE_4_MUL_SAT_EN to saturate dout on overflow instead of wrapping.
module case_4_mul_pipe #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 10,
  parameter int din1_WIDTH = 7,
  parameter int dout_WIDTH = 10
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  din_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int W = din0_WIDTH + din1_WIDTH;

  if (NUM_STAGE < 1 || NUM_STAGE > 8 || dout_WIDTH < 2 || dout_WIDTH > W || ID < 0) begin : g_bad_params
    $error("case_4_mul_pipe: illegal parameter combination");
  end

  // Returns {ovf, narrowed result} for a full-width product.
  function automatic logic [dout_WIDTH:0] narrow(input logic [W-1:0] p, input logic sgn);
    logic signed [W-1:0]   hi;
    logic                  o;
    logic [dout_WIDTH-1:0] r;
    hi = $signed(p) >>> (dout_WIDTH - 1);
    if (sgn) o = (hi != '0) && (hi != '1);
    else     o = (p >> dout_WIDTH) != '0;
    r = p[dout_WIDTH-1:0];
`ifdef CASE_4_MUL_SAT_EN
    if (o) begin
      if (!sgn)       r = '1;
      else if (p[W-1]) r = {1'b1, {(dout_WIDTH-1){1'b0}}};
      else            r = {1'b0, {(dout_WIDTH-1){1'b1}}};
    end
`endif
    return {o, r};
  endfunction

  logic                  stall;
  logic                  adv;
  logic [W-1:0]          a_ext;
  logic [W-1:0]          b_ext;
  logic [W-1:0]          prod;
  logic [W-1:0]          fin_p;
  logic                  fin_s;
  logic                  fin_v;
  logic [dout_WIDTH-1:0] dout_d, dout_q;
  logic                  ovf_d, ovf_q;
  logic                  out_vld_d, out_vld_q;

  assign stall    = out_vld_q & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = adv;

  // Sign- or zero-extend to the full width; the low W bits of the product are then correct in both modes.
  always_comb begin
    a_ext = {{(W-din0_WIDTH){din_signed & din0[din0_WIDTH-1]}}, din0};
    b_ext = {{(W-din1_WIDTH){din_signed & din1[din1_WIDTH-1]}}, din1};
    prod  = a_ext * b_ext;
  end

  if (NUM_STAGE == 1) begin : g_one
    assign fin_p = prod;
    assign fin_s = din_signed;
    assign fin_v = in_valid;
  end else begin : g_multi
    logic [W-1:0]           p_q [NUM_STAGE-1];
    logic [W-1:0]           p_d [NUM_STAGE-1];
    logic [NUM_STAGE-2:0]   s_q, s_d;
    logic [NUM_STAGE-2:0]   v_q, v_d;

    // Stage 1 captures the product; later stages shift it along with mode and valid.
    always_comb begin
      p_d[0] = prod;
      s_d    = '0;
      v_d    = '0;
      s_d[0] = din_signed;
      v_d[0] = in_valid;
      for (int i = 1; i < NUM_STAGE - 1; i++) begin
        p_d[i] = p_q[i-1];
        s_d[i] = s_q[i-1];
        v_d[i] = v_q[i-1];
      end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        for (int i = 0; i < NUM_STAGE - 1; i++) p_q[i] <= '0;
        s_q <= '0;
        v_q <= '0;
      end else if (adv) begin
        for (int i = 0; i < NUM_STAGE - 1; i++) p_q[i] <= p_d[i];
        s_q <= s_d;
        v_q <= v_d;
      end
    end

    assign fin_p = p_q[NUM_STAGE-2];
    assign fin_s = s_q[NUM_STAGE-2];
    assign fin_v = v_q[NUM_STAGE-2];
  end

  // Final stage: narrow the product and flag overflow.
  always_comb begin
    {ovf_d, dout_d} = narrow(fin_p, fin_s);
    out_vld_d       = fin_v;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dout_q    <= '0;
      ovf_q     <= 1'b0;
      out_vld_q <= 1'b0;
    end else if (adv) begin
      dout_q    <= dout_d;
      ovf_q     <= ovf_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign out_valid = out_vld_q;
  assign dout      = dout_q;
  assign ovf       = ovf_q;

endmodule
